// File: rtl/led_cube_frame_buffer.sv
// led_cube_frame_buffer
//   Double-buffered 64x8 frame store for an LED cube in stream mode (mode == 4'h3).
//   Incoming bytes fill the write bank; once 64 bytes are held, the banks swap on the
//   next frame_start. The read bank is only ever replaced on the edge after a
//   frame_start, so a displayed frame never tears.
//
//   Optional feature: define FB_SYNC_EN to hunt for an 8'hA5 sync byte before each frame.
//
// Ports
//   clk               in   system clock, rising edge
//   rst_n             in   asynchronous active-low reset
//   mode[3:0]         in   cube mode; buffer runs only when mode == 4'h3
//   data_in[7:0]      in   streamed frame byte
//   readdatavalid     in   data_in valid this cycle (no backpressure)
//   frame_start       in   one-cycle pulse marking a new displayed frame (swap point)
//   frame_addr[5:0]   in   byte index requested by the frame driver
//   data_to_latch     out  read bank byte at frame_addr, 0 when no frame is valid
//   frame_ready       out  a complete frame is waiting for a swap
//   overrun           out  sticky: a byte arrived while the buffer was full
//   stall_mode_change out  a frame is partially written; upstream must hold mode
module led_cube_frame_buffer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] mode,
    input  logic [7:0] data_in,
    input  logic       readdatavalid,
    input  logic       frame_start,
    input  logic [5:0] frame_addr,
    output logic [7:0] data_to_latch,
    output logic       frame_ready,
    output logic       overrun,
    output logic       stall_mode_change
);

`ifdef FB_SYNC_EN
    typedef enum logic [1:0] {StIdle = 2'd0, StFill = 2'd1, StFull = 2'd2, StHunt = 2'd3} state_e;
    localparam state_e StStart = StHunt;
`else
    typedef enum logic [1:0] {StIdle = 2'd0, StFill = 2'd1, StFull = 2'd2} state_e;
    localparam state_e StStart = StFill;
`endif

    localparam logic [7:0] SyncByte = 8'hA5;

    state_e     r_state;
    state_e     w_state_next;
    logic [5:0] r_wr_idx;
    logic [5:0] w_wr_idx_next;
    logic       r_rd_sel;
    logic       w_rd_sel_next;
    logic       r_rd_valid;
    logic       w_rd_valid_next;
    logic       r_overrun;
    logic       w_overrun_next;

    logic       w_mode_ok;
    logic       w_we;
    logic [6:0] w_waddr;

    // Both banks in one array: address bit 6 selects the bank.
    logic [7:0] r_bank [0:127];

    assign w_mode_ok = (mode == 4'h3);

    always_comb begin
        w_state_next    = r_state;
        w_wr_idx_next   = r_wr_idx;
        w_rd_sel_next   = r_rd_sel;
        w_rd_valid_next = r_rd_valid;
        w_overrun_next  = r_overrun;
        w_we            = 1'b0;
        w_waddr         = {~r_rd_sel, r_wr_idx};

        if (!w_mode_ok) begin
            // Leaving stream mode abandons any partial frame; banks and read selection stay.
            w_state_next   = StIdle;
            w_wr_idx_next  = 6'd0;
            w_overrun_next = 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    w_state_next  = StStart;
                    w_wr_idx_next = 6'd0;
                end
                StFill: begin
                    if (readdatavalid) begin
                        w_we          = 1'b1;
                        w_wr_idx_next = r_wr_idx + 6'd1;
                        if (r_wr_idx == 6'd63) begin
                            w_state_next = StFull;
                        end
                    end
                end
                StFull: begin
                    if (frame_start) begin
                        w_rd_sel_next   = ~r_rd_sel;
                        w_rd_valid_next = 1'b1;
                        w_state_next    = StStart;
                        w_wr_idx_next   = 6'd0;
`ifdef FB_SYNC_EN
                        // A coincident beat is the first hunted beat of the next frame.
                        if (readdatavalid && (data_in == SyncByte)) begin
                            w_state_next = StFill;
                        end
`else
                        // The old read bank becomes the write bank on this same edge.
                        if (readdatavalid) begin
                            w_we          = 1'b1;
                            w_waddr       = {r_rd_sel, 6'd0};
                            w_wr_idx_next = 6'd1;
                        end
`endif
                    end else if (readdatavalid) begin
                        w_overrun_next = 1'b1;
                    end
                end
`ifdef FB_SYNC_EN
                StHunt: begin
                    if (readdatavalid && (data_in == SyncByte)) begin
                        w_state_next  = StFill;
                        w_wr_idx_next = 6'd0;
                    end
                end
`endif
                default: begin
                    w_state_next = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_wr_idx   <= 6'd0;
            r_rd_sel   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wr_idx   <= w_wr_idx_next;
            r_rd_sel   <= w_rd_sel_next;
            r_rd_valid <= w_rd_valid_next;
            r_overrun  <= w_overrun_next;
        end
    end

    // Bank storage is not reset; rd_valid masks stale contents until the first swap.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_bank[w_waddr] <= data_in;
        end
    end

    assign data_to_latch     = (w_mode_ok && r_rd_valid) ? r_bank[{r_rd_sel, frame_addr}] : 8'h00;
    assign frame_ready       = (r_state == StFull);
    assign overrun           = r_overrun;
    assign stall_mode_change = (r_state == StFill) && (r_wr_idx != 6'd0);

endmodule

// File: tb/tb_led_cube_frame_buffer.sv
module tb_led_cube_frame_buffer;

    logic       clk;
    logic       rst_n;
    logic [3:0] mode;
    logic [7:0] data_in;
    logic       readdatavalid;
    logic       frame_start;
    logic [5:0] frame_addr;
    logic [7:0] data_to_latch;
    logic       frame_ready;
    logic       overrun;
    logic       stall_mode_change;

    led_cube_frame_buffer dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .mode              (mode),
        .data_in           (data_in),
        .readdatavalid     (readdatavalid),
        .frame_start       (frame_start),
        .frame_addr        (frame_addr),
        .data_to_latch     (data_to_latch),
        .frame_ready       (frame_ready),
        .overrun           (overrun),
        .stall_mode_change (stall_mode_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef FB_SYNC_EN
    localparam bit Sync = 1'b1;
`else
    localparam bit Sync = 1'b0;
`endif

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Reference model: the frame being collected is a queue of bytes; the displayed
    // frame is a plain 64-entry array copied from the queue on a swap.
    bit         m_active;
    bit         m_hunting;
    logic [7:0] m_pend[$];
    logic [7:0] m_shown[64];
    bit         m_shown_valid;
    bit         m_ovr;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active      = 1'b0;
        m_hunting     = 1'b0;
        m_pend.delete();
        m_shown_valid = 1'b0;
        m_ovr         = 1'b0;
    endtask

    task automatic check_model();
        logic [7:0] exp_data;
        logic       exp_ready;
        logic       exp_stall;
        exp_data  = (mode == 4'h3 && m_shown_valid) ? m_shown[frame_addr] : 8'h00;
        exp_ready = m_active && !m_hunting && (m_pend.size() == 64);
        exp_stall = m_active && !m_hunting && (m_pend.size() > 0) && (m_pend.size() < 64);
        check("data_to_latch", data_to_latch, exp_data);
        check("frame_ready", {7'd0, frame_ready}, {7'd0, exp_ready});
        check("overrun", {7'd0, overrun}, {7'd0, m_ovr});
        check("stall_mode_change", {7'd0, stall_mode_change}, {7'd0, exp_stall});
    endtask

    // Effect of one rising edge with the currently driven inputs.
    task automatic model_edge();
        if (mode != 4'h3) begin
            m_active = 1'b0;
            m_pend.delete();
            m_ovr    = 1'b0;
        end else if (!m_active) begin
            m_active  = 1'b1;
            m_hunting = Sync;
            m_pend.delete();
        end else if (m_hunting) begin
            if (readdatavalid && data_in == 8'hA5) m_hunting = 1'b0;
        end else if (m_pend.size() == 64) begin
            if (frame_start) begin
                for (int i = 0; i < 64; i++) m_shown[i] = m_pend[i];
                m_shown_valid = 1'b1;
                m_pend.delete();
                m_hunting = Sync;
                if (readdatavalid) begin
                    if (Sync) begin
                        if (data_in == 8'hA5) m_hunting = 1'b0;
                    end else begin
                        m_pend.push_back(data_in);
                    end
                end
            end else if (readdatavalid) begin
                m_ovr = 1'b1;
            end
        end else if (readdatavalid) begin
            m_pend.push_back(data_in);
        end
    endtask

    // One clock cycle: drive at the falling edge, check, then advance the model on the rising edge.
    task automatic cyc(input logic [3:0] m, input logic [7:0] d, input logic v, input logic f,
                       input logic [5:0] a);
        mode          = m;
        data_in       = d;
        readdatavalid = v;
        frame_start   = f;
        frame_addr    = a;
        #1;
        check_model();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic beat(input logic [7:0] d);
        cyc(4'h3, d, 1'b1, 1'b0, 6'($urandom_range(0, 63)));
    endtask

    task automatic sync_prefix();
        if (Sync) begin
            beat(8'h11);
            beat(8'hA5);
        end
    endtask

    // Reset asserted between clock edges; outputs must clear without waiting for a clock.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst data_to_latch", data_to_latch, 8'h00);
        check("rst frame_ready", {7'd0, frame_ready}, 8'h00);
        check("rst overrun", {7'd0, overrun}, 8'h00);
        check("rst stall", {7'd0, stall_mode_change}, 8'h00);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        mode          = 4'h3;
        data_in       = 8'h00;
        readdatavalid = 1'b0;
        frame_start   = 1'b0;
        frame_addr    = 6'd0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        async_reset();

        // First frame 0x00..0x3F; nothing valid to display yet.
        cyc(4'h3, 8'h00, 1'b0, 1'b0, 6'd0);
        sync_prefix();
        for (int i = 0; i < 64; i++) begin
            if (i == 30) check("stall after 30", {7'd0, stall_mode_change}, 8'h01);
            if (i == 1) check("no swap yet data", data_to_latch, 8'h00);
            beat(8'(i));
        end
        check("ready after 64", {7'd0, frame_ready}, 8'h01);
        cyc(4'h3, 8'h00, 1'b0, 1'b1, 6'd5);
        cyc(4'h3, 8'h00, 1'b0, 1'b0, 6'd5);
        check("addr5 after swap", data_to_latch, 8'h05);

        // Overrun on an extra beat when full, cleared by leaving stream mode.
        sync_prefix();
        for (int i = 0; i < 64; i++) beat(8'($urandom));
        beat(8'hEE);
        check("overrun set", {7'd0, overrun}, 8'h01);
        cyc(4'h0, 8'h00, 1'b0, 1'b0, 6'd0);
        check("overrun cleared", {7'd0, overrun}, 8'h00);

`ifndef FB_SYNC_EN
        // Beat coincident with frame_start lands at index 0 of the next frame.
        cyc(4'h3, 8'h00, 1'b0, 1'b0, 6'd0);
        for (int i = 0; i < 64; i++) beat(8'($urandom));
        cyc(4'h3, 8'h77, 1'b1, 1'b1, 6'd0);
        check("no overrun on swap+beat", {7'd0, overrun}, 8'h00);
        for (int i = 0; i < 63; i++) beat(8'($urandom));
        cyc(4'h3, 8'h00, 1'b0, 1'b1, 6'd0);
        cyc(4'h3, 8'h00, 1'b0, 1'b0, 6'd0);
        check("coincident byte at 0", data_to_latch, 8'h77);
`endif

        // Reset mid-frame discards the partial frame.
        cyc(4'h3, 8'h00, 1'b0, 1'b0, 6'd0);
        sync_prefix();
        for (int i = 0; i < 40; i++) beat(8'($urandom));
        async_reset();
        cyc(4'h3, 8'h00, 1'b0, 1'b0, 6'd0);
        sync_prefix();
        for (int i = 0; i < 63; i++) beat(8'($urandom));
        check("not ready at 63", {7'd0, frame_ready}, 8'h00);
        beat(8'($urandom));
        check("ready at 64", {7'd0, frame_ready}, 8'h01);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] m;
            logic [7:0] d;
            m = ($urandom_range(0, 199) == 0) ? 4'($urandom_range(0, 15)) : 4'h3;
            d = ($urandom_range(0, 15) == 0) ? 8'hA5 : 8'($urandom);
            cyc(m, d, 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0),
                6'($urandom_range(0, 63)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/led_cube_frame_buffer.md
LED_CUBE_FRAME_BUFFER -- requirements
Module: led_cube_frame_buffer

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 mode  input  4  cube mode select; buffer active only when mode == 4'h3 (stream mode).
REQ-004 data_in  input  8  streamed frame byte; one LED column byte per beat.
REQ-005 readdatavalid  input  1  data_in valid this cycle; no backpressure exists, and the source never waits.
REQ-006 frame_start  input  1  one-cycle pulse from the frame sequencer marking the start of a new displayed frame; this is the only legal swap point.
REQ-007 frame_addr  input  6  byte index (0..63) requested by the frame driver.
REQ-008 data_to_latch  output  8  byte at frame_addr in the read bank.
REQ-009 frame_ready  output  1  high while a complete frame is waiting for swap (state FULL).
REQ-010 overrun  output  1  sticky flag: a byte arrived while no bank could accept it.
REQ-011 stall_mode_change  output  1  high while a frame is partially written; upstream holds mode while high.

Function
REQ-012 The buffer SHALL hold two 64x8 banks: one write bank and one read bank, selected by a 1-bit rd_sel register.
REQ-013 The read path SHALL be combinational: data_to_latch = read bank[frame_addr] when mode == 4'h3 and rd_valid == 1, else 8'h00.
REQ-014 The FSM SHALL have states IDLE, FILL and FULL, plus HUNT when FB_SYNC_EN is defined.
REQ-015 IDLE -> FILL (or HUNT) SHALL occur on the first cycle with mode == 4'h3, and wr_idx SHALL be cleared to 0.
REQ-016 In FILL, each readdatavalid beat SHALL write data_in to write bank[wr_idx] and increment wr_idx.
REQ-017 A write at wr_idx == 63 SHALL move the FSM to FULL and wrap wr_idx to 0 (6-bit wrap).
REQ-018 In FULL, frame_start SHALL toggle rd_sel, set rd_valid, and return the FSM to FILL (or HUNT) in the same edge.
REQ-019 A swap SHALL take effect on the clock edge after the frame_start cycle; the read bank SHALL never change during a displayed frame.
REQ-020 readdatavalid in FULL without frame_start SHALL drop the byte and set overrun.
REQ-021 readdatavalid and frame_start together in FULL SHALL perform the swap and write the byte to index 0 of the new write bank; wr_idx becomes 1 and overrun is not set.
REQ-022 frame_start in IDLE or FILL SHALL be ignored.
REQ-023 mode != 4'h3 in any state SHALL force IDLE on the next edge and clear wr_idx and overrun; bank contents, rd_sel and rd_valid are retained.
REQ-024 stall_mode_change SHALL be 1 exactly when the state is FILL and wr_idx != 0.
REQ-025 frame_ready SHALL be 1 exactly when the state is FULL.

Reset
REQ-026 Asserting rst_n low SHALL immediately set: state IDLE, wr_idx 0, rd_sel 0, rd_valid 0, overrun 0.
REQ-027 Consequently, during reset data_to_latch, frame_ready and stall_mode_change SHALL all be 0.
REQ-028 Bank contents SHALL NOT be reset; they are masked by rd_valid == 0 until the first swap.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; no swap occurs.

Configuration
REQ-030 Macro FB_SYNC_EN: when defined, the FSM enters HUNT instead of FILL.
- HUNT discards beats until data_in == 8'hA5 with readdatavalid; that beat is not stored, and the FSM moves to FILL.
- Beats discarded in HUNT do not set overrun.
- stall_mode_change is 0 in HUNT.
- When FB_SYNC_EN is undefined, HUNT does not exist and every 64 consecutive beats form one frame.

Verification
REQ-031 Reset, then mode=3, 64 beats of 8'h00..8'h3F, then frame_start pulse -> frame_ready high after beat 64; after the swap, frame_addr=5 gives data_to_latch=8'h05.
REQ-032 Before any swap, mode=3 and frame_addr=0 -> data_to_latch=8'h00; after 30 beats, stall_mode_change=1.
REQ-033 Bank full, 1 extra beat without frame_start -> overrun=1 and the byte is lost; switching mode to 0 clears overrun=0.
REQ-034 Bank full, beat 8'h77 coincident with frame_start -> swap occurs, overrun=0; after the next frame completes and swaps, frame_addr=0 gives 8'h77.
REQ-035 Reset asserted after 40 beats -> all outputs 0 immediately; after release, 64 new beats are needed for frame_ready.
REQ-036 With FB_SYNC_EN defined: beats 8'h11, 8'hA5, then 64 bytes -> the first stored byte is the one after 8'hA5, and frame_ready rises after the 64th byte.
